// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register sequencer: FSM states, step indices,
// completion error codes and the byte-command helpers used to drive the byte master.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RSP,
    S_STOP_ISSUE,
    S_STOP_WAIT,
    S_DONE
  } seq_state_t;

  // Step 2 is the data byte for writes and the repeated start for reads.
  localparam logic [1:0] STEP_ADDR = 2'd0;
  localparam logic [1:0] STEP_REG  = 2'd1;
  localparam logic [1:0] STEP_MID  = 2'd2;
  localparam logic [1:0] STEP_READ = 2'd3;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_WDG  = 2'd3;

  typedef struct packed {
    logic       start;
    logic       rw;
    logic [7:0] data;
  } cmd_t;

  function automatic logic [7:0] pack_addr(input logic [6:0] addr7, input logic rw);
    return {addr7, rw};
  endfunction

  function automatic cmd_t step_cmd(
    input logic [1:0] step,
    input logic       rd,
    input logic [6:0] dev,
    input logic [7:0] reg_idx,
    input logic [7:0] wbyte
  );
    cmd_t c;
    c = '{start: 1'b0, rw: 1'b0, data: 8'h00};
    case (step)
      STEP_ADDR: begin
        c.start = 1'b1;
        c.data  = pack_addr(dev, 1'b0);
      end
      STEP_REG: c.data = reg_idx;
      STEP_MID: begin
        if (rd) begin
          c.start = 1'b1;
          c.data  = pack_addr(dev, 1'b1);
        end else begin
          c.data = wbyte;
        end
      end
      default: c.rw = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/i2c_rsp_watchdog.sv
// Clearable saturating counter with a terminal-count flag; the sequencer reuses it
// both as the response watchdog and as the post-stop hold timer.
module i2c_rsp_watchdog #(
  parameter int CNT_W = 22
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_terminal,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != i_terminal)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == i_terminal);

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Register-level transaction sequencer: turns one register read/write request into the
// start/write/read/stop byte-command stream for the I2C byte master and reports completion.
module i2c_reg_sequencer
  import i2c_pkg::*;
#(
  parameter int RSP_TIMEOUT = 2000000,
  parameter int STOP_HOLD   = 1000,
  parameter int CNT_W       = 22
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req,
  input  logic       req_rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic [1:0] err,
  output logic [7:0] m_data_w,
  output logic       m_start,
  output logic       m_stop,
  output logic       m_rw,
  output logic       m_go,
  input  logic [7:0] m_data_r,
  input  logic       m_ack,
  input  logic       m_nack,
  input  logic       m_timeout
);

  localparam logic [CNT_W-1:0] RSP_TC  = CNT_W'(RSP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(STOP_HOLD - 1);

  seq_state_t       r_state;
  logic [1:0]       r_step;
  logic             r_rw;
  logic [6:0]       r_dev;
  logic [7:0]       r_reg;
  logic [7:0]       r_wdata;

  logic             w_tc;
  logic             w_clear;
  logic             w_enable;
  logic [CNT_W-1:0] w_terminal;
  logic [1:0]       w_last_step;
  cmd_t             w_cmd;

  // One counter serves both waits; its terminal value follows the state.
  assign w_clear     = (r_state == S_ISSUE) || (r_state == S_STOP_ISSUE);
  assign w_enable    = (r_state == S_WAIT_RSP) || (r_state == S_STOP_WAIT);
  assign w_terminal  = (r_state == S_STOP_WAIT) ? HOLD_TC : RSP_TC;
  assign w_last_step = r_rw ? STEP_READ : STEP_MID;
  assign w_cmd       = step_cmd(r_step, r_rw, r_dev, r_reg, r_wdata);

  i2c_rsp_watchdog #(
    .CNT_W(CNT_W)
  ) u_watchdog (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_clear   (w_clear),
    .i_enable  (w_enable),
    .i_terminal(w_terminal),
    .o_tc      (w_tc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_step   <= STEP_ADDR;
      r_rw     <= 1'b0;
      r_dev    <= '0;
      r_reg    <= '0;
      r_wdata  <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      rdata    <= '0;
      err      <= ERR_OK;
      m_data_w <= '0;
      m_start  <= 1'b0;
      m_stop   <= 1'b0;
      m_rw     <= 1'b0;
      m_go     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (req) begin
            r_rw    <= req_rw;
            r_dev   <= dev_addr;
            r_reg   <= reg_addr;
            r_wdata <= wdata;
            r_step  <= STEP_ADDR;
            ready   <= 1'b0;
            err     <= ERR_OK;
            rdata   <= '0;
            r_state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          m_go     <= 1'b1;
          m_stop   <= 1'b0;
          m_start  <= w_cmd.start;
          m_rw     <= w_cmd.rw;
          m_data_w <= w_cmd.data;
          r_state  <= S_WAIT_RSP;
        end

        // Timeout outranks the watchdog, which outranks nack, which outranks ack.
        S_WAIT_RSP: begin
          m_go <= 1'b0;
          if (m_timeout || w_tc || m_nack) begin
            err      <= m_timeout ? ERR_TMO : (w_tc ? ERR_WDG : ERR_NACK);
            m_start  <= 1'b0;
            m_rw     <= 1'b0;
            m_data_w <= '0;
            r_state  <= S_STOP_ISSUE;
          end else if (m_ack) begin
            if (r_rw && (r_step == STEP_READ)) begin
              rdata <= m_data_r;
            end
            m_start  <= 1'b0;
            m_rw     <= 1'b0;
            m_data_w <= '0;
            if (r_step == w_last_step) begin
              r_state <= S_STOP_ISSUE;
            end else begin
              r_step  <= r_step + 2'd1;
              r_state <= S_ISSUE;
            end
          end
        end

        S_STOP_ISSUE: begin
          m_stop  <= 1'b1;
          m_go    <= 1'b1;
          r_state <= S_STOP_WAIT;
        end

        S_STOP_WAIT: begin
          m_go <= 1'b0;
          if (w_tc) begin
            m_stop  <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Self-checking bench for i2c_reg_sequencer: a scripted byte-master responder plus a
// transaction-level model of the expected command stream, error code and read data.
module tb_i2c_reg_sequencer;

  localparam int RSP_TIMEOUT = 100;
  localparam int STOP_HOLD   = 20;
  localparam int CNT_W       = 22;
  localparam int WAIT_BOUND  = 3000;

  localparam int K_ACK    = 0;
  localparam int K_NACK   = 1;
  localparam int K_TMO    = 2;
  localparam int K_NONE   = 3;
  localparam int K_TMOACK = 4;

  localparam int C_START = 0;
  localparam int C_WRITE = 1;
  localparam int C_READ  = 2;
  localparam int C_STOP  = 3;

  typedef struct packed {
    logic            rw;
    logic [6:0]      dev;
    logic [7:0]      regA;
    logic [7:0]      wd;
    logic [7:0]      rbyte;
    logic [3:0][2:0] kind;
    logic [3:0][6:0] dly;
    logic [1:0]      expErr;
    logic [7:0]      expRdata;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req = 1'b0;
  logic       req_rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] m_data_r = '0;
  logic       m_ack = 1'b0;
  logic       m_nack = 1'b0;
  logic       m_timeout = 1'b0;
  logic       ready;
  logic       done;
  logic [7:0] rdata;
  logic [1:0] err;
  logic [7:0] m_data_w;
  logic       m_start;
  logic       m_stop;
  logic       m_rw;
  logic       m_go;

  int checks = 0;
  int fails = 0;

  int planKind[4];
  int planDly[4];
  logic [7:0] planRbyte;
  int rspIdx = 0;
  bit rspActive = 0;
  int rspPend = 0;
  int rspKindNow = 0;
  int doneCount = 0;
  int cmdQ[$];
  int expQ[$];
  logic [1:0] expErrM;
  logic [7:0] expRdM;

  always #5 clock = ~clock;

  i2c_reg_sequencer #(
    .RSP_TIMEOUT(RSP_TIMEOUT),
    .STOP_HOLD  (STOP_HOLD),
    .CNT_W      (CNT_W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .req_rw   (req_rw),
    .dev_addr (dev_addr),
    .reg_addr (reg_addr),
    .wdata    (wdata),
    .ready    (ready),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .m_data_w (m_data_w),
    .m_start  (m_start),
    .m_stop   (m_stop),
    .m_rw     (m_rw),
    .m_go     (m_go),
    .m_data_r (m_data_r),
    .m_ack    (m_ack),
    .m_nack   (m_nack),
    .m_timeout(m_timeout)
  );

  // Byte-master stand-in: logs every command and answers each byte per the current plan.
  always @(negedge clock) begin
    m_ack = 1'b0;
    m_nack = 1'b0;
    m_timeout = 1'b0;
    if (rspActive) begin
      if (rspPend == 0) begin
        rspActive = 0;
        m_data_r = planRbyte;
        case (rspKindNow)
          K_ACK:    m_ack = 1'b1;
          K_NACK:   m_nack = 1'b1;
          K_TMO:    m_timeout = 1'b1;
          K_TMOACK: begin m_timeout = 1'b1; m_ack = 1'b1; end
          default:  ;
        endcase
      end else begin
        rspPend--;
      end
    end
    if (done) doneCount++;
    if (m_go) begin
      if (m_stop)       cmdQ.push_back(C_STOP * 256);
      else if (m_start) cmdQ.push_back(C_START * 256 + int'(m_data_w));
      else if (m_rw)    cmdQ.push_back(C_READ * 256);
      else              cmdQ.push_back(C_WRITE * 256 + int'(m_data_w));
      if (!m_stop && rspIdx < 4) begin
        rspKindNow = planKind[rspIdx];
        rspPend = planDly[rspIdx];
        rspActive = (rspKindNow != K_NONE);
        rspIdx++;
      end
    end
  end

  function automatic vec_t mkVec(input logic rw, input logic [6:0] dev, input logic [7:0] regA,
                                 input logic [7:0] wd, input logic [7:0] rbyte,
                                 input int k0, input int k1, input int k2, input int k3,
                                 input int d0, input int d1, input int d2, input int d3,
                                 input logic [1:0] eErr, input logic [7:0] eRd);
    vec_t v;
    v = '0;
    v.rw = rw; v.dev = dev; v.regA = regA; v.wd = wd; v.rbyte = rbyte;
    v.kind[0] = 3'(k0); v.kind[1] = 3'(k1); v.kind[2] = 3'(k2); v.kind[3] = 3'(k3);
    v.dly[0] = 7'(d0); v.dly[1] = 7'(d1); v.dly[2] = 7'(d2); v.dly[3] = 7'(d3);
    v.expErr = eErr; v.expRdata = eRd;
    return v;
  endfunction

  // Reference: the byte list of the request, cut short at the first failing byte, then a stop.
  // A byte's answer lands RSP_TIMEOUT-1 counts after its go at the latest before the watchdog wins.
  task automatic buildExpected(input vec_t v);
    int steps[$];
    int arrival;
    int k;
    int wdg;
    expQ.delete();
    expErrM = 2'd0;
    expRdM = 8'h00;
    wdg = RSP_TIMEOUT - 1;
    steps.push_back(C_START * 256 + int'({v.dev, 1'b0}));
    steps.push_back(C_WRITE * 256 + int'(v.regA));
    if (v.rw) begin
      steps.push_back(C_START * 256 + int'({v.dev, 1'b1}));
      steps.push_back(C_READ * 256);
    end else begin
      steps.push_back(C_WRITE * 256 + int'(v.wd));
    end
    for (int i = 0; i < steps.size(); i++) begin
      expQ.push_back(steps[i]);
      arrival = int'(v.dly[i]) + 1;
      k = int'(v.kind[i]);
      if (k == K_NONE || arrival > wdg) begin
        expErrM = 2'd3;
        break;
      end else if (k == K_TMO || k == K_TMOACK) begin
        expErrM = 2'd2;
        break;
      end else if (arrival == wdg) begin
        expErrM = 2'd3;
        break;
      end else if (k == K_NACK) begin
        expErrM = 2'd1;
        break;
      end
      if (steps[i] / 256 == C_READ) expRdM = v.rbyte;
    end
    expQ.push_back(C_STOP * 256);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setPlan(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      planKind[i] = int'(v.kind[i]);
      planDly[i] = int'(v.dly[i]);
    end
    planRbyte = v.rbyte;
    rspIdx = 0;
    rspActive = 0;
    doneCount = 0;
    cmdQ.delete();
  endtask

  task automatic issueReq(input vec_t v);
    int guard;
    guard = 0;
    while (!ready && guard < WAIT_BOUND) begin
      @(negedge clock);
      guard++;
    end
    if (!ready) checkOutput("ready_wait_timeout", 32'(ready), 32'd1);
    req = 1'b1;
    req_rw = v.rw;
    dev_addr = v.dev;
    reg_addr = v.regA;
    wdata = v.wd;
    @(negedge clock);
    req = 1'b0;
  endtask

  task automatic waitAndCheck(input vec_t v);
    int guard;
    guard = 0;
    while (!done && guard < WAIT_BOUND) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("done_seen", 32'(done), 32'd1);
    checkOutput("err", 32'(err), 32'(v.expErr));
    checkOutput("rdata", 32'(rdata), 32'(v.expRdata));
    @(negedge clock);
    checkOutput("done_width", 32'(done), 32'd0);
    checkOutput("ready_after", 32'(ready), 32'd1);
    checkOutput("err_hold", 32'(err), 32'(v.expErr));
    checkOutput("done_count", 32'(doneCount), 32'd1);
    buildExpected(v);
    checkOutput("cmd_count", 32'(cmdQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < cmdQ.size(); i++) begin
      checkOutput($sformatf("cmd%0d", i), 32'(cmdQ[i]), 32'(expQ[i]));
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    setPlan(v);
    issueReq(v);
    waitAndCheck(v);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_rdata"}, 32'(rdata), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_m_data_w"}, 32'(m_data_w), 32'd0);
    checkOutput({tag, "_m_ctl"}, 32'({m_start, m_stop, m_rw, m_go}), 32'd0);
  endtask

  vec_t tbl[12];

  initial begin
    vec_t v;
    vec_t busy;
    int guard;
    int r;

    tbl[0]  = mkVec(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, K_ACK, K_ACK, K_ACK, K_ACK, 2, 2, 2, 2, 2'd0, 8'h00);
    tbl[1]  = mkVec(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, K_ACK, K_ACK, K_ACK, K_ACK, 3, 3, 3, 3, 2'd0, 8'h3C);
    tbl[2]  = mkVec(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, K_NACK, K_ACK, K_ACK, K_ACK, 1, 1, 1, 1, 2'd1, 8'h00);
    tbl[3]  = mkVec(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, K_ACK, K_TMO, K_ACK, K_ACK, 1, 4, 1, 1, 2'd2, 8'h00);
    tbl[4]  = mkVec(1'b0, 7'h2A, 8'h33, 8'h5A, 8'h00, K_ACK, K_TMOACK, K_ACK, K_ACK, 0, 2, 0, 0, 2'd2, 8'h00);
    tbl[5]  = mkVec(1'b0, 7'h13, 8'h44, 8'h77, 8'h00, K_NONE, K_ACK, K_ACK, K_ACK, 0, 0, 0, 0, 2'd3, 8'h00);
    tbl[6]  = mkVec(1'b1, 7'h7F, 8'hFF, 8'h00, 8'h5A, K_ACK, K_ACK, K_ACK, K_ACK, 0, 0, 0, 97, 2'd0, 8'h5A);
    tbl[7]  = mkVec(1'b1, 7'h7F, 8'hFF, 8'h00, 8'h5A, K_ACK, K_ACK, K_ACK, K_ACK, 0, 0, 0, 98, 2'd3, 8'h00);
    tbl[8]  = mkVec(1'b1, 7'h01, 8'h00, 8'h00, 8'h99, K_ACK, K_ACK, K_ACK, K_NACK, 1, 1, 1, 1, 2'd1, 8'h00);
    tbl[9]  = mkVec(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, K_ACK, K_ACK, K_NACK, K_ACK, 1, 1, 5, 1, 2'd1, 8'h00);
    tbl[10] = mkVec(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, K_ACK, K_ACK, K_TMO, K_ACK, 0, 0, 98, 0, 2'd2, 8'h00);
    tbl[11] = mkVec(1'b0, 7'h50, 8'h01, 8'h02, 8'h00, K_TMO, K_ACK, K_ACK, K_ACK, 0, 0, 0, 0, 2'd2, 8'h00);

    repeat (3) @(negedge clock);
    #1;
    checkResetOutputs("in_reset");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checkResetOutputs("after_reset");

    // Stray master pulses while idle must not start or complete anything.
    #1 m_ack = 1'b1;
    m_nack = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("idle_stray_ready", 32'(ready), 32'd1);
    checkOutput("idle_stray_done", 32'(doneCount), 32'd0);
    checkOutput("idle_stray_go", 32'(cmdQ.size()), 32'd0);

    for (int i = 0; i < 12; i++) begin
      $display("[TB] table vector %0d", i);
      applyStimulus(tbl[i]);
    end

    // A request arriving while busy is dropped, not queued.
    busy = tbl[0];
    setPlan(busy);
    issueReq(busy);
    repeat (5) @(negedge clock);
    req = 1'b1; req_rw = 1'b1; dev_addr = 7'h11; reg_addr = 8'h66;
    @(negedge clock);
    req = 1'b0;
    waitAndCheck(busy);
    repeat (40) @(negedge clock);
    checkOutput("busy_req_dropped_done", 32'(doneCount), 32'd1);
    checkOutput("busy_req_dropped_cmds", 32'(cmdQ.size()), 32'd4);

    // Reset while holding after the stop: silent abandon, then a clean transaction.
    setPlan(tbl[0]);
    issueReq(tbl[0]);
    guard = 0;
    while (!(cmdQ.size() > 0 && cmdQ[cmdQ.size() - 1] == C_STOP * 256) && guard < WAIT_BOUND) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("stop_seen_before_reset", 32'(guard < WAIT_BOUND), 32'd1);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkResetOutputs("mid_reset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    checkOutput("no_done_after_reset", 32'(doneCount), 32'd0);
    checkOutput("ready_after_reset", 32'(ready), 32'd1);
    applyStimulus(tbl[1]);

    for (int n = 0; n < 30; n++) begin
      v = mkVec(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                K_ACK, K_ACK, K_ACK, K_ACK, 0, 0, 0, 0, 2'd0, 8'h00);
      for (int s = 0; s < 4; s++) begin
        r = int'($urandom_range(0, 11));
        case (r)
          0:       v.kind[s] = 3'(K_NACK);
          1:       v.kind[s] = 3'(K_TMO);
          2:       v.kind[s] = 3'(K_NONE);
          3:       v.kind[s] = 3'(K_TMOACK);
          default: v.kind[s] = 3'(K_ACK);
        endcase
        if ($urandom_range(0, 7) == 0) v.dly[s] = 7'($urandom_range(95, 98));
        else                           v.dly[s] = 7'($urandom_range(0, 15));
      end
      buildExpected(v);
      v.expErr = expErrM;
      v.expRdata = expRdM;
      applyStimulus(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
